// File: rtl/wb_bus_bridge.sv
// wb_bus_bridge: single-master Wishbone interconnect with a registered address
// decode. Each master request is latched, routed to exactly one slave strobe,
// and completed with a one-cycle ACK, or with a one-cycle ERR when the address
// decodes to no slave or the slave fails to answer within TIMEOUT cycles.
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | waiting for m_stb; request latched and decoded on the sample edge
// BUSY    | one slave strobed, waiting for its ACK or for the timer to expire
// RESP    | m_ack visible for this single cycle
// WAITLOW | transfer done; wait for m_stb to drop so a held strobe cannot
//         | re-issue the same transfer
module wb_bus_bridge #(
  parameter int NUM_SLAVES = 5,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SEL_LO     = 28,
  parameter int SEL_W      = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_stb,
  input  logic                         m_we,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_dat_i,
  output logic [DATA_W-1:0]            m_dat_o,
  output logic                         m_ack,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_stb,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_dat_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]        s_ack
);

  // The timer only ever holds 0..TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, WAITLOW} state_t;

  state_t                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   s_stb_q, s_stb_d;
  logic                    s_we_q, s_we_d;
  logic [ADDR_W-1:0]       s_addr_q, s_addr_d;
  logic [DATA_W-1:0]       s_dat_q, s_dat_d;
  logic [DATA_W-1:0]       m_dat_q, m_dat_d;
  logic                    m_ack_q, m_ack_d;
  logic                    m_err_q, m_err_d;
  logic [TW-1:0]           timer_q, timer_d;

  logic [SEL_W-1:0]        req_idx;
  logic [NUM_SLAVES-1:0]   dec_stb;
  logic                    req_hit;
  logic                    sel_ack;
  logic [DATA_W-1:0]       sel_dat;

  // Decode the incoming address into a one-hot strobe; an out-of-range index
  // yields all zeros, which is the decode miss.
  always_comb begin
    req_idx = m_addr[SEL_LO +: SEL_W];
    dec_stb = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      dec_stb[k] = (32'(req_idx) == 32'(k));
    end
    req_hit = |dec_stb;
  end

  // The held one-hot strobe doubles as the read-data/ACK mux select, so ACKs
  // from slaves that are not strobed never reach the FSM.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (s_stb_q[k]) begin
        sel_ack = sel_ack | s_ack[k];
        sel_dat = sel_dat | s_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and output-register logic; everything holds unless changed,
  // and the ACK/ERR pulses default low.
  always_comb begin
    state_d  = state_q;
    s_stb_d  = s_stb_q;
    s_we_d   = s_we_q;
    s_addr_d = s_addr_q;
    s_dat_d  = s_dat_q;
    m_dat_d  = m_dat_q;
    timer_d  = timer_q;
    m_ack_d  = 1'b0;
    m_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_stb) begin
          s_we_d   = m_we;
          s_addr_d = m_addr;
          s_dat_d  = m_dat_i;
          timer_d  = '0;
          if (req_hit) begin
            s_stb_d = dec_stb;
            state_d = BUSY;
          end else begin
            m_err_d = 1'b1;
            state_d = WAITLOW;
          end
        end
      end
      BUSY: begin
        if (sel_ack) begin
          m_dat_d = sel_dat;
          s_stb_d = '0;
          m_ack_d = 1'b1;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          s_stb_d = '0;
          m_err_d = 1'b1;
          state_d = WAITLOW;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        state_d = WAITLOW;
      end
      WAITLOW: begin
        if (!m_stb) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      s_stb_q  <= '0;
      s_we_q   <= 1'b0;
      s_addr_q <= '0;
      s_dat_q  <= '0;
      m_dat_q  <= '0;
      m_ack_q  <= 1'b0;
      m_err_q  <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      s_stb_q  <= s_stb_d;
      s_we_q   <= s_we_d;
      s_addr_q <= s_addr_d;
      s_dat_q  <= s_dat_d;
      m_dat_q  <= m_dat_d;
      m_ack_q  <= m_ack_d;
      m_err_q  <= m_err_d;
      timer_q  <= timer_d;
    end
  end

  assign s_stb   = s_stb_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_dat_o = s_dat_q;
  assign m_dat_o = m_dat_q;
  assign m_ack   = m_ack_q;
  assign m_err   = m_err_q;

endmodule
